ldly: RTL
=========

# ldly

Pulse delay line: each single-cycle pulse on `in` reappears as a single-cycle pulse on `p` exactly `DELAY` clocks later. Several pulses may be in flight at once, like a physical delay line. The block sits directly downstream of the pulse amplifiers and DCD gates, whose one-cycle pulses it consumes. Its output `p` drives further pulse-chain stages, implementing the machine's timed pulse chains (e.g. 1 µs = 50 clocks at 50 MHz).

## Interface
- `DELAY`, default 50: delay in clocks. Legal range 2..255.
- `SLOTS`, default 4: maximum number of pulses in flight. Legal range 1..8.
- `clk`  in  1: 50 MHz system clock; all state changes on the rising edge.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `in`  in  1: input pulse. Sampled every edge; each high cycle is one pulse.
- `clr`  in  1: synchronous clear. Cancels every in-flight pulse and clears `ovf`.
- `p`  out  1: delayed output pulse, registered, one cycle wide per accepted pulse.
- `busy`  out  1: level, high while any slot is occupied.
- `count`  out  $clog2(SLOTS+1): number of occupied slots.
- `ovf`  out  1: sticky overflow flag; a pulse was dropped.

## Operation
- State: `SLOTS` independent slots, each holding a valid bit and a countdown counter of width $clog2(DELAY).
- Reset value of every output is 0: `p`=0, `busy`=0, `count`=0, `ovf`=0. All slots are invalid.
- Accepting a pulse (`in`=1, `clr`=0):
  - The lowest-index free slot is loaded with `DELAY-1` and marked valid.
  - A slot that expires on the same edge counts as free and may be reused.
- Each edge, every valid slot decrements. A slot at 1 expires: it becomes invalid and `p` is registered high for the next cycle.
- At most one slot can expire per edge, because acceptance is at most one per edge. `p` is therefore never wider than one cycle per pulse.
- Overflow: if `in`=1, all slots are valid and none is expiring, the pulse is dropped. `ovf` is set on that edge and stays 1 until `clr` or reset.
- `clr`=1 on an edge:
  - All slots are invalidated, `p`=0 and `ovf`=0 for the next cycle.
  - A simultaneous `in` is ignored (clr wins).
  - A slot expiring on that edge does not produce `p`.
- `count` = popcount of the valid bits. `busy` = (`count` != 0). Both are registered from the post-edge slot state.
- Reset mid-operation: all in-flight pulses are lost and no `p` is ever produced for them. After `reset_n` rises, the first edge behaves as from idle.

## Timing
- `in` high in cycle n leads to `p` high in cycle n+DELAY only. Latency is exact, independent of slot index or load.
- The slot is occupied (counted in `count`/`busy`) during cycles n+1..n+DELAY-1. In cycle n+DELAY, `p`=1 and that slot is free.
- Consecutive input pulses in cycles n, n+1, … produce `p` in cycles n+DELAY, n+DELAY+1, …, order preserved.
- `ovf` rises in the cycle after the dropping edge.
- `reset_n` low clears all outputs immediately, without waiting for a clock edge. Release is synchronous to the next edge.
- No combinational path from any input to any output.

## Test plan
- DELAY=5, SLOTS=4: `in` in cycle 10 → `p`=1 in cycle 15 only; `busy`=1, `count`=1 in cycles 11–14; all 0 in cycle 15.
- DELAY=5, SLOTS=4: `in` high cycles 10–14 (five pulses) → `p` in cycles 15–19; the cycle-14 pulse reuses the slot expiring that edge; `ovf` stays 0; `count` = 1,2,3,4,4 in cycles 11–15.
- DELAY=8, SLOTS=4: `in` high cycles 10–14 → `p` in cycles 18,19,20,21 and none in cycle 22; `ovf`=1 from cycle 15; `clr` in cycle 30 → `ovf`=0 in cycle 31.
- DELAY=5: pulses in cycles 10 and 11, `clr` in cycle 12, `in` also high in cycle 12 → `count`=0 from cycle 13; no `p` in cycles 15–17.
- DELAY=5: pulse in cycle 10, `reset_n` low mid-cycle 12 → outputs 0 at once, without waiting for an edge; release in cycle 14 → no `p` in cycle 15; new pulse in cycle 16 → `p` in cycle 21.
- DELAY=2, SLOTS=1: `in` high every cycle 10–15 → `p` high cycles 12–17; `ovf`=0.

Source files
------------

// File: rtl/ldly.sv
// Pulse delay line: every accepted one-cycle pulse on `in` is replayed on `p`
// exactly DELAY clocks later, with up to SLOTS pulses in flight at once.
module ldly #(
    parameter int DELAY = 50,
    parameter int SLOTS = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in,
    input  logic                         clr,
    output logic                         p,
    output logic                         busy,
    output logic [$clog2(SLOTS+1)-1:0]   count,
    output logic                         ovf
);
    localparam int CW = $clog2(DELAY);
    localparam int NW = $clog2(SLOTS+1);
    localparam logic [CW-1:0] LOAD = CW'(DELAY - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [SLOTS-1:0] r_vld;
    logic [CW-1:0]    r_cnt [SLOTS];
    logic             r_p;
    logic             r_busy;
    logic             r_ovf;
    logic [NW-1:0]    r_count;

    logic [SLOTS-1:0] w_exp;
    logic [SLOTS-1:0] w_free;
    logic [SLOTS-1:0] w_load;
    logic [SLOTS-1:0] w_vld_nxt;
    logic [NW-1:0]    w_pop;
    logic             w_accept;
    logic             w_drop;
    logic             w_fire;

    // A slot expiring on this edge is already free for a new pulse.
    always_comb begin
        w_exp  = '0;
        w_free = '0;
        for (int i = 0; i < SLOTS; i++) begin
            w_exp[i]  = r_vld[i] && (r_cnt[i] == ONE);
            w_free[i] = !r_vld[i] || w_exp[i];
        end
    end

    always_comb begin : pick_slot
        logic w_found;
        w_found = 1'b0;
        w_load  = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (w_free[i] && !w_found) begin
                w_load[i] = 1'b1;
                w_found   = 1'b1;
            end
        end
    end

    assign w_accept = in && !clr && (|w_free);
    assign w_drop   = in && !clr && !(|w_free);
    assign w_fire   = (|w_exp) && !clr;

    always_comb begin
        w_vld_nxt = '0;
        w_pop     = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (clr)
                w_vld_nxt[i] = 1'b0;
            else if (w_accept && w_load[i])
                w_vld_nxt[i] = 1'b1;
            else if (w_exp[i])
                w_vld_nxt[i] = 1'b0;
            else
                w_vld_nxt[i] = r_vld[i];
            w_pop = w_pop + NW'(w_vld_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld   <= '0;
            r_p     <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else begin
            r_vld   <= w_vld_nxt;
            r_p     <= w_fire;
            r_busy  <= |w_vld_nxt;
            r_ovf   <= clr ? 1'b0 : (r_ovf | w_drop);
            r_count <= w_pop;
        end
    end

    // Countdown values are only meaningful while the slot's valid bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SLOTS; i++) begin
            if (w_accept && w_load[i])
                r_cnt[i] <= LOAD;
            else if (r_vld[i])
                r_cnt[i] <= r_cnt[i] - ONE;
        end
    end

    assign p     = r_p;
    assign busy  = r_busy;
    assign count = r_count;
    assign ovf   = r_ovf;
endmodule
